// File: rtl/updown_counter_mod_if.sv
// Control/status bundle for updown_counter_mod: count controls in, count state out.
// master drives the controls, slave is the counter itself.
interface updown_counter_mod_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             zero;

    modport master (
        output en,
        output up,
        output load,
        output load_val,
        input  q,
        input  tc,
        input  zero
    );

    modport slave (
        input  en,
        input  up,
        input  load,
        input  load_val,
        output q,
        output tc,
        output zero
    );
endinterface

// File: rtl/updown_counter_mod.sv
// Synchronous up/down counter with modulus, wrap/saturate mode, enable prescaler,
// parallel load and a registered terminal-count pulse.
module updown_counter_mod #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    updown_counter_mod_if.slave bus
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PreLast = PW'(PRESCALE - 1);

    if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : gen_bad_modulus
        $fatal(1, "updown_counter_mod: MODULUS out of range 2..2**WIDTH");
    end
    if (PRESCALE < 1) begin : gen_bad_prescale
        $fatal(1, "updown_counter_mod: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             step;

    assign step = bus.en && (pre_q == PreLast);

    always_comb begin
        q_d   = q_q;
        pre_d = pre_q;
        tc_d  = 1'b0;
        if (bus.load) begin
            q_d   = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
            pre_d = '0;
        end else if (bus.en) begin
            pre_d = step ? '0 : pre_q + 1'b1;
            if (step) begin
                if (bus.up) begin
                    if (q_q < MaxVal) begin
                        q_d = q_q + 1'b1;
                    end else begin
                        // At the top limit: wrap to zero or hold, flagging either way.
                        q_d  = SATURATE ? q_q : '0;
                        tc_d = 1'b1;
                    end
                end else begin
                    if (q_q != '0) begin
                        q_d = q_q - 1'b1;
                    end else begin
                        q_d  = SATURATE ? q_q : MaxVal;
                        tc_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            pre_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            pre_q <= pre_d;
            tc_q  <= tc_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.tc   = tc_q;
    assign bus.zero = (q_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: wrap, saturate and prescaled instances,
// all WIDTH=4 MODULUS=10, sharing one clock and reset.
module tb_updown_counter_mod;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    updown_counter_mod_if #(.WIDTH(4)) w_if ();
    updown_counter_mod_if #(.WIDTH(4)) s_if ();
    updown_counter_mod_if #(.WIDTH(4)) p_if ();

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (w_if.slave)
    );
    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );
    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .PRESCALE(3)) u_pre (
        .clk (clk),
        .rst (rst),
        .bus (p_if.slave)
    );

    logic [3:0] t1_q  [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic       t1_tc [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [3:0] t4_q  [9]  = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        w_if.en = 0; w_if.up = 1; w_if.load = 0; w_if.load_val = '0;
        s_if.en = 0; s_if.up = 1; s_if.load = 0; s_if.load_val = '0;
        p_if.en = 0; p_if.up = 1; p_if.load = 0; p_if.load_val = '0;
        tick();
        chk("rst w q", w_if.q, 0);
        chk("rst w tc", w_if.tc, 0);
        chk("rst w zero", w_if.zero, 1);
        chk("rst s q", s_if.q, 0);
        chk("rst p q", p_if.q, 0);
        chk("rst p tc", p_if.tc, 0);
        rst = 1'b0;

        // 1: wrap up, every enabled cycle steps
        w_if.en = 1; w_if.up = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("t1 q[%0d]", i), w_if.q, t1_q[i]);
            chk($sformatf("t1 tc[%0d]", i), w_if.tc, t1_tc[i]);
        end
        chk("t1 zero at q=2", w_if.zero, 0);

        // 2: reset overrides enable, then wrap down from zero
        rst = 1;
        tick();
        chk("t2 rst q", w_if.q, 0);
        chk("t2 rst tc", w_if.tc, 0);
        chk("t2 rst zero", w_if.zero, 1);
        rst = 0; w_if.up = 0;
        tick(); chk("t2 q0", w_if.q, 9); chk("t2 tc0", w_if.tc, 1);
        tick(); chk("t2 q1", w_if.q, 8); chk("t2 tc1", w_if.tc, 0);
        tick(); chk("t2 q2", w_if.q, 7); chk("t2 tc2", w_if.tc, 0);
        w_if.en = 0;
        tick(); chk("t2 hold q", w_if.q, 7); chk("t2 hold tc", w_if.tc, 0);

        // 3: saturate at both limits
        s_if.load = 1; s_if.load_val = 4'd8;
        tick(); chk("t3 load q", s_if.q, 8); chk("t3 load tc", s_if.tc, 0);
        s_if.load = 0; s_if.en = 1; s_if.up = 1;
        tick(); chk("t3 up0 q", s_if.q, 9); chk("t3 up0 tc", s_if.tc, 0);
        tick(); chk("t3 up1 q", s_if.q, 9); chk("t3 up1 tc", s_if.tc, 1);
        tick(); chk("t3 up2 q", s_if.q, 9); chk("t3 up2 tc", s_if.tc, 1);
        s_if.up = 0;
        tick(); chk("t3 dn q", s_if.q, 8); chk("t3 dn tc", s_if.tc, 0);
        s_if.en = 0; s_if.load = 1; s_if.load_val = 4'd0;
        tick(); chk("t3 load0 q", s_if.q, 0);
        s_if.load = 0; s_if.en = 1;
        tick(); chk("t3 dn0 q", s_if.q, 0); chk("t3 dn0 tc", s_if.tc, 1);
        s_if.en = 0;
        tick(); chk("t3 en0 tc", s_if.tc, 0); chk("t3 en0 q", s_if.q, 0);

        // 4: prescale by 3, then a 2-cycle enable gap mid-phase
        p_if.en = 1; p_if.up = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("t4 q[%0d]", i), p_if.q, t4_q[i]);
            chk($sformatf("t4 tc[%0d]", i), p_if.tc, 0);
        end
        tick(); chk("t4 ph1 q", p_if.q, 3);
        p_if.en = 0;
        tick(); chk("t4 gap0 q", p_if.q, 3);
        tick(); chk("t4 gap1 q", p_if.q, 3);
        p_if.en = 1;
        tick(); chk("t4 ph2 q", p_if.q, 3);
        tick(); chk("t4 slip q", p_if.q, 4);
        // direction change mid-phase keeps the prescale phase
        tick(); chk("t4 dir0 q", p_if.q, 4);
        p_if.up = 0;
        tick(); chk("t4 dir1 q", p_if.q, 4);
        tick(); chk("t4 dir2 q", p_if.q, 3);

        // 5: load clears the prescaler and clamps
        p_if.up = 1;
        tick(); chk("t5 pre1 q", p_if.q, 3);
        p_if.load = 1; p_if.load_val = 4'd7;
        tick(); chk("t5 load q", p_if.q, 7); chk("t5 load tc", p_if.tc, 0);
        p_if.load = 0;
        tick(); chk("t5 a q", p_if.q, 7);
        tick(); chk("t5 b q", p_if.q, 7);
        tick(); chk("t5 c q", p_if.q, 8);
        p_if.load = 1; p_if.load_val = 4'd12;
        tick(); chk("t5 clamp q", p_if.q, 9);
        w_if.load = 1; w_if.load_val = 4'd15;
        p_if.load = 0;
        tick(); chk("t5 w clamp q", w_if.q, 9); chk("t5 w clamp tc", w_if.tc, 0);
        w_if.load = 0;
        chk("t5 p wrap a q", p_if.q, 9);
        tick(); chk("t5 p wrap b q", p_if.q, 9);
        tick(); chk("t5 p wrap q", p_if.q, 0); chk("t5 p wrap tc", p_if.tc, 1);
        tick(); chk("t5 p after tc", p_if.tc, 0);

        // 6: reset beats a simultaneous load
        p_if.en = 0; p_if.load = 1; p_if.load_val = 4'd6;
        tick(); chk("t6 load6 q", p_if.q, 6);
        p_if.load = 0; p_if.en = 1;
        tick(); chk("t6 pre q", p_if.q, 6);
        rst = 1; p_if.load = 1; p_if.load_val = 4'd5;
        tick(); chk("t6 rst q", p_if.q, 0); chk("t6 rst tc", p_if.tc, 0);
        chk("t6 rst zero", p_if.zero, 1);
        rst = 0; p_if.load = 0;
        tick(); chk("t6 r0 q", p_if.q, 0);
        tick(); chk("t6 r1 q", p_if.q, 0);
        tick(); chk("t6 r2 q", p_if.q, 1); chk("t6 r2 zero", p_if.zero, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
